// File: rtl/sift_uart_pkg.sv
// Shared types and framing constants for the host<->FPGA UART loaders.
package sift_uart_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_UPPER = 2'd1,
        WAIT_LOWER = 2'd2,
        DONE       = 2'd3
    } rx_state_t;

    localparam int BYTE_W          = 8;
    localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling, LSB first.
// valid_o / err_o pulse for one cycle at the stop-bit sample.
module uart_rx
    import sift_uart_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = 50
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              rx,
    output logic [BYTE_W-1:0] data_o,
    output logic              valid_o,
    output logic              err_o
);

    localparam int CNT_W     = $clog2(CLOCKS_PER_BAUD + 1);
    localparam int DATA_BITS = UART_FRAME_BITS - 2;
    localparam int IDX_W     = $clog2(DATA_BITS);

    typedef enum logic [1:0] {BIT_IDLE, BIT_START, BIT_DATA, BIT_STOP} bit_state_t;

    bit_state_t        state_reg, state_next;
    logic              rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0]  baud_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [BYTE_W-1:0] shift_reg;
    logic              half_done, bit_done, last_bit;

    assign half_done = (baud_cnt == CNT_W'(CLOCKS_PER_BAUD / 2 - 1));
    assign bit_done  = (baud_cnt == CNT_W'(CLOCKS_PER_BAUD - 1));
    assign last_bit  = (bit_idx == IDX_W'(DATA_BITS - 1));
    assign data_o    = shift_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BIT_IDLE:  if (rx_prev && !rx_sync) state_next = BIT_START;
            // A start bit that is high again at its centre was a glitch.
            BIT_START: if (half_done) state_next = rx_sync ? BIT_IDLE : BIT_DATA;
            BIT_DATA:  if (bit_done && last_bit) state_next = BIT_STOP;
            BIT_STOP:  if (bit_done) state_next = BIT_IDLE;
            default:   state_next = BIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_reg <= BIT_IDLE;
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            valid_o   <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            state_reg <= state_next;
            valid_o   <= 1'b0;
            err_o     <= 1'b0;

            if (state_reg == BIT_IDLE || state_reg != state_next || bit_done)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + CNT_W'(1);

            if (state_reg == BIT_START)
                bit_idx <= '0;

            if (state_reg == BIT_DATA && bit_done) begin
                shift_reg <= {rx_sync, shift_reg[BYTE_W-1:1]};
                bit_idx   <= bit_idx + IDX_W'(1);
            end

            if (state_reg == BIT_STOP && bit_done) begin
                valid_o <= rx_sync;
                err_o   <= !rx_sync;
            end
        end
    end

endmodule

// File: rtl/receive_image.sv
// Host->FPGA image loader: assembles two UART bytes per word and writes them to BRAM.
// Optional `RX_TIMEOUT_EN drops an orphan upper byte after TIMEOUT_CYCLES idle cycles.
module receive_image
    import sift_uart_pkg::*;
#(
    parameter int BRAM_LENGTH     = 1000,
    parameter int BIT_DEPTH       = 13,
    parameter int CLOCKS_PER_BAUD = 50,
    parameter int TIMEOUT_CYCLES  = 2000
) (
    input  logic                           clk,
    input  logic                           rst_in,
    input  logic                           rx,
    input  logic                           arm_in,
    output logic [$clog2(BRAM_LENGTH)-1:0] address,
    output logic [BIT_DEPTH-1:0]           data_out,
    output logic                           we,
    output logic                           busy,
    output logic                           image_received,
    output logic                           frame_err,
    output logic                           resync,
    output logic [1:0]                     out_state
);

    localparam int ADDR_W = $clog2(BRAM_LENGTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BRAM_LENGTH - 1);

    generate
        if (BIT_DEPTH < 9 || BIT_DEPTH > 16) begin : g_bad_depth
            $error("receive_image: BIT_DEPTH must be in 9..16");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("receive_image: TIMEOUT_CYCLES must be positive");
        end
    endgenerate

    rx_state_t         state_reg, state_next;
    logic [BYTE_W-1:0] upper_byte;
    logic [BYTE_W-1:0] rx_byte;
    logic              byte_valid, byte_err;
    logic              timeout_hit;

    uart_rx #(
        .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
    ) u_uart_rx (
        .clk    (clk),
        .rst_in (rst_in),
        .rx     (rx),
        .data_o (rx_byte),
        .valid_o(byte_valid),
        .err_o  (byte_err)
    );

`ifdef RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_cnt;

    assign timeout_hit = (state_reg == WAIT_LOWER) && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in)
            idle_cnt <= '0;
        else if (state_reg != WAIT_LOWER || byte_valid)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + TO_W'(1);
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign out_state = state_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:       if (arm_in) state_next = WAIT_UPPER;
            WAIT_UPPER: if (byte_valid) state_next = WAIT_LOWER;
            WAIT_LOWER: begin
                if (byte_valid)
                    state_next = (address == LAST_ADDR) ? DONE : WAIT_UPPER;
                else if (timeout_hit)
                    state_next = WAIT_UPPER;
            end
            DONE:       state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_reg      <= IDLE;
            upper_byte     <= '0;
            address        <= '0;
            data_out       <= '0;
            we             <= 1'b0;
            busy           <= 1'b0;
            image_received <= 1'b0;
            frame_err      <= 1'b0;
            resync         <= 1'b0;
        end else begin
            state_reg      <= state_next;
            we             <= 1'b0;
            image_received <= 1'b0;
            resync         <= 1'b0;
            frame_err      <= byte_err;

            // Advance one cycle after the write so address stays stable under we.
            if (we && address != LAST_ADDR)
                address <= address + ADDR_W'(1);

            case (state_reg)
                IDLE: begin
                    if (arm_in) begin
                        address <= '0;
                        busy    <= 1'b1;
                    end
                end
                WAIT_UPPER: begin
                    if (byte_valid)
                        upper_byte <= rx_byte;
                end
                WAIT_LOWER: begin
                    if (byte_valid) begin
                        data_out <= BIT_DEPTH'({upper_byte, rx_byte});
                        we       <= 1'b1;
                    end else if (timeout_hit) begin
                        upper_byte <= '0;
                        resync     <= 1'b1;
                    end
                end
                DONE: begin
                    image_received <= 1'b1;
                    busy           <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_receive_image.sv
// Self-checking bench for receive_image: UART byte driver, write scoreboard, scenario tasks.
// Exercises the timeout scenario differently when RX_TIMEOUT_EN is defined.
module tb_receive_image;

    localparam int CPB = 8;
    localparam int LEN = 4;
    localparam int BD  = 13;

    logic          clk = 1'b0;
    logic          rst_in = 1'b1;
    logic          rx = 1'b1;
    logic          arm_in = 1'b0;
    logic [1:0]    address;
    logic [BD-1:0] data_out;
    logic          we, busy, image_received, frame_err, resync;
    logic [1:0]    out_state;

    int vectors = 0;
    int miscompares = 0;
    int ir_count = 0;
    int fe_count = 0;
    int rs_count = 0;
    bit expect_ir = 1'b0;

    typedef struct {
        logic [1:0]    addr;
        logic [BD-1:0] data;
        bit            last;
    } exp_t;
    exp_t exp_q[$];

    receive_image #(
        .BRAM_LENGTH    (LEN),
        .BIT_DEPTH      (BD),
        .CLOCKS_PER_BAUD(CPB),
        .TIMEOUT_CYCLES (2000)
    ) dut (
        .clk           (clk),
        .rst_in        (rst_in),
        .rx            (rx),
        .arm_in        (arm_in),
        .address       (address),
        .data_out      (data_out),
        .we            (we),
        .busy          (busy),
        .image_received(image_received),
        .frame_err     (frame_err),
        .resync        (resync),
        .out_state     (out_state)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_in) begin
            expect_ir = 1'b0;
        end else begin
            if (expect_ir) begin
                vectors++;
                if (image_received !== 1'b1 || busy !== 1'b0 || out_state !== 2'd0) begin
                    miscompares++;
                    $display("FAIL done_pulse: ir=%b busy=%b state=%0d, expected ir=1 busy=0 state=0",
                             image_received, busy, out_state);
                end
                expect_ir = 1'b0;
            end else if (image_received === 1'b1) begin
                miscompares++;
                $display("FAIL stray_done: image_received=1, expected 0");
            end
            if (we === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL stray_we: addr %0d data %h, expected no write", address, data_out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("write addr %0d data %h (expected addr %0d data %h)", address, data_out, e.addr, e.data);
                    if (address !== e.addr || data_out !== e.data) begin
                        miscompares++;
                        $display("FAIL we_word: addr %0d data %h, expected addr %0d data %h",
                                 address, data_out, e.addr, e.data);
                    end
                    if (e.last) begin
                        expect_ir = 1'b1;
                        if (out_state !== 2'd3) begin
                            miscompares++;
                            $display("FAIL last_state: state %0d, expected 3", out_state);
                        end
                    end
                end
            end
            if (image_received === 1'b1) ir_count++;
            if (frame_err === 1'b1) fe_count++;
            if (resync === 1'b1) rs_count++;
        end
    end

    task automatic push_word(input int a, input logic [7:0] u, input logic [7:0] l);
        exp_t e;
        logic [15:0] w;
        w = {u, l} & 16'h1FFF;
        e.addr = 2'(a);
        e.data = w[BD-1:0];
        e.last = (a == LEN - 1);
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = good_stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_in = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic arm();
        @(negedge clk);
        arm_in = 1'b1;
        @(negedge clk);
        arm_in = 1'b0;
        vectors++;
        if (busy !== 1'b1 || address !== 2'd0 || out_state !== 2'd1) begin
            miscompares++;
            $display("FAIL arm: busy=%b addr=%0d state=%0d, expected busy=1 addr=0 state=1",
                     busy, address, out_state);
        end
    endtask

    task automatic test_reset();
        #13;
        vectors++;
        if ({address, data_out, we, busy, image_received, frame_err, resync, out_state} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: addr=%0d data=%h we=%b busy=%b ir=%b fe=%b rs=%b state=%0d, expected all 0",
                     address, data_out, we, busy, image_received, frame_err, resync, out_state);
        end
        @(negedge clk);
        rst_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_word();
        arm();
        push_word(0, 8'h1A, 8'h2B);
        send_byte(8'h1A, 1'b1);
        send_byte(8'h2B, 1'b1);
        vectors++;
        if (busy !== 1'b1 || out_state !== 2'd1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL single_word: busy=%b state=%0d pending=%0d, expected busy=1 state=1 pending=0",
                     busy, out_state, exp_q.size());
        end
    endtask

    task automatic test_full_image();
        logic [7:0] ups [4] = '{8'h00, 8'hFF, 8'h0A, 8'h1C};
        logic [7:0] lows[4] = '{8'h01, 8'h12, 8'h0B, 8'hDE};
        int ir_before;
        pulse_reset();
        arm();
        ir_before = ir_count;
        for (int i = 0; i < LEN; i++) begin
            push_word(i, ups[i], lows[i]);
            send_byte(ups[i], 1'b1);
            send_byte(lows[i], 1'b1);
        end
        vectors++;
        if (ir_count - ir_before != 1 || busy !== 1'b0 || out_state !== 2'd0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL full_image: done_pulses=%0d busy=%b state=%0d pending=%0d, expected 1 0 0 0",
                     ir_count - ir_before, busy, out_state, exp_q.size());
        end
    endtask

    task automatic test_idle_bytes();
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        vectors++;
        if (address !== 2'd3 || out_state !== 2'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_bytes: addr=%0d state=%0d busy=%b, expected addr=3 state=0 busy=0",
                     address, out_state, busy);
        end
        arm();
        push_word(0, 8'h01, 8'h02);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        vectors++;
        if (exp_q.size() != 0 || address !== 2'd1) begin
            miscompares++;
            $display("FAIL rearm: pending=%0d addr=%0d, expected 0 and 1", exp_q.size(), address);
        end
    endtask

    task automatic test_frame_error();
        int fe_before;
        fe_before = fe_count;
        send_byte(8'h05, 1'b1);
        send_byte(8'hEE, 1'b0);
        vectors++;
        if (fe_count - fe_before != 1 || out_state !== 2'd2 || we !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_err: pulses=%0d state=%0d we=%b, expected 1 2 0",
                     fe_count - fe_before, out_state, we);
        end
        push_word(1, 8'h05, 8'h77);
        send_byte(8'h77, 1'b1);
        vectors++;
        if (exp_q.size() != 0 || address !== 2'd2) begin
            miscompares++;
            $display("FAIL frame_recover: pending=%0d addr=%0d, expected 0 and 2", exp_q.size(), address);
        end
    endtask

    task automatic test_async_reset();
        pulse_reset();
        arm();
        push_word(0, 8'h11, 8'h22);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1 ^ i[0];
            repeat (CPB) @(negedge clk);
        end
        #2;
        rst_in = 1'b1;
        #1;
        vectors++;
        if ({address, data_out, we, busy, image_received, frame_err, resync, out_state} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: addr=%0d data=%h busy=%b state=%0d, expected all 0",
                     address, data_out, busy, out_state);
        end
        exp_q.delete();
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_in = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        arm();
        push_word(0, 8'h44, 8'h55);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        vectors++;
        if (exp_q.size() != 0 || address !== 2'd1) begin
            miscompares++;
            $display("FAIL after_reset: pending=%0d addr=%0d, expected 0 and 1", exp_q.size(), address);
        end
    endtask

    task automatic test_timeout();
        int rs_before;
        rs_before = rs_count;
        send_byte(8'h09, 1'b1);
        repeat (2100) @(negedge clk);
`ifdef RX_TIMEOUT_EN
        vectors++;
        if (rs_count - rs_before != 1 || out_state !== 2'd1 || address !== 2'd1) begin
            miscompares++;
            $display("FAIL timeout: resync=%0d state=%0d addr=%0d, expected 1 1 1",
                     rs_count - rs_before, out_state, address);
        end
        push_word(1, 8'h03, 8'h04);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
`else
        vectors++;
        if (rs_count != rs_before || out_state !== 2'd2) begin
            miscompares++;
            $display("FAIL no_timeout: resync=%0d state=%0d, expected 0 and 2",
                     rs_count - rs_before, out_state);
        end
        push_word(1, 8'h09, 8'h04);
        send_byte(8'h04, 1'b1);
`endif
        vectors++;
        if (exp_q.size() != 0 || address !== 2'd2) begin
            miscompares++;
            $display("FAIL timeout_word: pending=%0d addr=%0d, expected 0 and 2", exp_q.size(), address);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full_image();
        test_idle_bytes();
        test_frame_error();
        test_async_reset();
        test_timeout();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
